anim_sprite_draw: RTL
=====================

# anim_sprite_draw

Parametrised, animated successor to the single-bitmap VGA object drawer. For each pixel coordinate it returns an RGB332 colour and a drawing request for a W×H sprite drawn from one of FRAMES bitmaps. A frame-rate state machine steps through the bitmaps, and the frame index changes only on VGA frame boundaries. Sits between the VGA coordinate generator and the priority/mux layer, one instance per on-screen object.

## Interface
Parameters:
- OBJ_W, 26, sprite width in pixels
- OBJ_H, 26, sprite height in pixels
- FRAMES, 4, number of animation bitmaps (≥1)
- TICKS_PER_FRAME, 8, VGA frames each bitmap is held (≥1)
- COORD_W, 11, coordinate width
- TRANSPARENT, 8'hFF, colour value treated as "not drawn"

Ports:
- CLK  in  1  pixel clock
- RESETn  in  1  reset, asynchronous, active-low
- oCoord_X  in  COORD_W  current pixel X
- oCoord_Y  in  COORD_W  current pixel Y
- ObjectStartX  in  COORD_W  sprite top-left X
- ObjectStartY  in  COORD_W  sprite top-left Y
- startOfFrame  in  1  one-cycle pulse per VGA frame
- play  in  1  level; start/continue animation
- loop  in  1  level; 1 = wrap to frame 0 after the last frame, 0 = stop at the last frame
- drawing_request  out  1  pixel is inside the sprite and not transparent
- mVGA_RGB  out  8  pixel colour (RGB332)
- frame_idx  out  $clog2(FRAMES) (min 1)  bitmap currently displayed
- anim_done  out  1  one-cycle pulse on entering DONE

## Operation
- Hit test is done in COORD_W+1 bits, so the end coordinate ObjectStart+OBJ_W cannot wrap.
- inside = X∈[StartX, StartX+OBJ_W) and Y∈[StartY, StartY+OBJ_H).
- Offsets are dx = X−StartX and dy = Y−StartY. Both are forced to 0 when the pixel is not inside.
- Colour = rom[frame_idx][dy][dx]. The row index is not flipped.
- drawing_request = inside && colour ≠ TRANSPARENT. mVGA_RGB carries the ROM value regardless.
- State machine (the only events are startOfFrame pulses; a tick counter runs 0..TICKS_PER_FRAME−1):
  - IDLE: frame_idx=0, tick=0. On play=1 → PLAY.
  - PLAY: each startOfFrame increments tick. At tick=TICKS_PER_FRAME−1 the tick clears and frame_idx advances.
    - Past the last frame with loop=1: frame_idx=0, stay in PLAY.
    - Past the last frame with loop=0: hold the last frame, → DONE, pulse anim_done.
    - play=0 sampled on a startOfFrame: → IDLE (frame 0).
  - DONE: hold the last frame. play=0 → IDLE.
- frame_idx updates only in the cycle after a startOfFrame pulse. No mid-frame tearing.
- FRAMES=1: PLAY never advances. With loop=0, DONE is entered after TICKS_PER_FRAME ticks.
- startOfFrame and a play change in the same cycle: the state transition is evaluated with the new play value.

## Timing
- Pixel path has two register stages.
  - Stage 1 registers inside, dx, dy and frame_idx.
  - Stage 2 registers the ROM output, mVGA_RGB and drawing_request.
- Latency from oCoord to outputs is 2 CLK. Throughput is 1 pixel/clock.
- Animation path:
  - Every register in the FSM and tick counter updates on the same edge.
  - anim_done is high for exactly the 1 cycle after the startOfFrame that causes PLAY→DONE.
- Reset values (asynchronous, held throughout RESETn low):
  - drawing_request=0, mVGA_RGB=0, frame_idx=0, anim_done=0
  - state=IDLE, tick=0, pipeline valid=0
- Reset mid-animation returns to IDLE/frame 0 immediately.

## Configuration
- SPRITE_MIRROR_EN defined:
  - Adds input port mirror_x (1 bit).
  - When mirror_x=1, the ROM column is OBJ_W−1−dx. mirror_x is sampled in stage 1 and has the same 2-cycle latency.
- Not defined: the port is absent and the column is always dx.

## Structure
- Package sprite_pkg holds:
  - typedef rgb332_t (logic [7:0])
  - enum anim_state_t {IDLE, PLAY, DONE}
  - constant TRANSPARENT_DEFAULT = 8'hFF
- One sub-module, sprite_rom: parameters OBJ_W, OBJ_H, FRAMES; registered read of (frame, row, col); bitmap contents held in its initial data.
- Counters and the FSM stay in the top module.

## Test plan
- Pixel hit test: StartX=100, StartY=50. Scan (99..126, 49..76) → drawing_request only at X 100..125, Y 50..75, and only where the ROM ≠ 8'hFF. Outputs lag the coordinates by exactly 2 CLK.
- Edge wrap: StartX=2040, OBJ_W=26 → no hits at X 0..20, and hits at 2040..2047 where the ROM is opaque.
- Looping animation: play=1, loop=1, FRAMES=4, TICKS=8. Send 40 startOfFrame pulses → frame_idx sequence 0,1,2,3,0 changing every 8 pulses. anim_done never fires.
- One-shot: loop=0, same setup → after 32 pulses frame_idx=3, state DONE, anim_done high for one cycle. Further pulses leave it unchanged. play=0 → frame_idx=0.
- Reset mid-frame: assert RESETn=0 while frame_idx=2 and the pixel path is active → all outputs 0 on the same edge. After release, IDLE with frame 0.
- With SPRITE_MIRROR_EN: mirror_x=1, pixel at dx=0 → colour equals rom column OBJ_W−1 of the current frame.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared types, constants and helpers for the animated sprite drawer.
//   rgb332_t             8-bit RGB332 pixel colour
//   anim_state_t         animation FSM states (IDLE, PLAY, DONE)
//   TRANSPARENT_DEFAULT  colour value treated as "not drawn"
//   idx_width()          index width for a count, never below 1 bit
//   sprite_pixel()       bitmap pattern used to populate the sprite ROM
package sprite_pkg;

    typedef logic [7:0] rgb332_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } anim_state_t;

    localparam rgb332_t TRANSPARENT_DEFAULT = 8'hFF;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bitmap content: the main diagonal (row == col) is transparent, every
    // other pixel encodes frame/row/column so each frame is distinguishable.
    function automatic rgb332_t sprite_pixel(input int unsigned frame,
                                             input int unsigned row,
                                             input int unsigned col);
        if (row == col) begin
            return TRANSPARENT_DEFAULT;
        end
        return {2'(frame % 4), 3'(row % 8), 3'(col % 8)};
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// sprite_rom
// Registered-read bitmap store holding FRAMES bitmaps of OBJ_W x OBJ_H
// RGB332 pixels. Contents come from sprite_pkg::sprite_pixel().
// Ports:
//   CLK     in   pixel clock
//   RESETn  in   asynchronous active-low reset (clears the read register)
//   frame   in   bitmap select
//   row     in   row within the bitmap
//   col     in   column within the bitmap
//   data    out  registered pixel colour, one cycle after the address
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int OBJ_W  = 26,
    parameter int OBJ_H  = 26,
    parameter int FRAMES = 4,
    localparam int FW = idx_width(FRAMES),
    localparam int RW = idx_width(OBJ_H),
    localparam int CW = idx_width(OBJ_W)
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic [FW-1:0] frame,
    input  logic [RW-1:0] row,
    input  logic [CW-1:0] col,
    output rgb332_t       data
);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            data <= '0;
        end else begin
            data <= sprite_pixel(32'(frame), 32'(row), 32'(col));
        end
    end

endmodule

// File: rtl/anim_sprite_draw.sv
// anim_sprite_draw
// Animated W x H sprite drawer. For each pixel coordinate it returns an
// RGB332 colour and a drawing request, 2 CLK after the coordinate, one pixel
// per clock. A frame-rate FSM steps through FRAMES bitmaps, changing the
// displayed bitmap only right after a startOfFrame pulse.
// Optional build macro: SPRITE_MIRROR_EN adds mirror_x (horizontal flip).
// Ports:
//   CLK, RESETn              pixel clock, asynchronous active-low reset
//   oCoord_X, oCoord_Y       current pixel coordinate
//   ObjectStartX/Y           sprite top-left corner
//   startOfFrame             one-cycle pulse per VGA frame
//   play, loop               animation control levels
//   mirror_x                 (SPRITE_MIRROR_EN only) flip columns
//   drawing_request          pixel inside sprite and opaque
//   mVGA_RGB                 pixel colour (ROM value, even when not drawn)
//   frame_idx                bitmap currently displayed
//   anim_done                one-cycle pulse on entering DONE
module anim_sprite_draw
    import sprite_pkg::*;
#(
    parameter int      OBJ_W           = 26,
    parameter int      OBJ_H           = 26,
    parameter int      FRAMES          = 4,
    parameter int      TICKS_PER_FRAME = 8,
    parameter int      COORD_W         = 11,
    parameter rgb332_t TRANSPARENT     = TRANSPARENT_DEFAULT,
    localparam int     FW              = idx_width(FRAMES)
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic [COORD_W-1:0] oCoord_X,
    input  logic [COORD_W-1:0] oCoord_Y,
    input  logic [COORD_W-1:0] ObjectStartX,
    input  logic [COORD_W-1:0] ObjectStartY,
    input  logic               startOfFrame,
    input  logic               play,
    input  logic               loop,
`ifdef SPRITE_MIRROR_EN
    input  logic               mirror_x,
`endif
    output logic               drawing_request,
    output rgb332_t            mVGA_RGB,
    output logic [FW-1:0]      frame_idx,
    output logic               anim_done
);

    localparam int CW = idx_width(OBJ_W);
    localparam int RW = idx_width(OBJ_H);
    localparam int TW = idx_width(TICKS_PER_FRAME);
    localparam int EW = COORD_W + 1;

    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(TICKS_PER_FRAME - 1);

    // ------------------------------------------------------------------
    // Hit test, one bit wider than the coordinates so Start+W cannot wrap
    // ------------------------------------------------------------------
    logic [EW-1:0] x_ext, y_ext, sx_ext, sy_ext, ex_ext, ey_ext;
    logic          inside_c;
    logic [CW-1:0] dx_c;
    logic [RW-1:0] dy_c;

    assign x_ext  = {1'b0, oCoord_X};
    assign y_ext  = {1'b0, oCoord_Y};
    assign sx_ext = {1'b0, ObjectStartX};
    assign sy_ext = {1'b0, ObjectStartY};
    assign ex_ext = sx_ext + EW'(OBJ_W);
    assign ey_ext = sy_ext + EW'(OBJ_H);

    assign inside_c = (x_ext >= sx_ext) && (x_ext < ex_ext) &&
                      (y_ext >= sy_ext) && (y_ext < ey_ext);

    // Offsets are zeroed outside the sprite so the ROM is never addressed
    // out of range.
    assign dx_c = inside_c ? CW'(x_ext - sx_ext) : '0;
    assign dy_c = inside_c ? RW'(y_ext - sy_ext) : '0;

    // ------------------------------------------------------------------
    // Stage 1: hit result, offsets and the frame being displayed
    // ------------------------------------------------------------------
    logic          valid_s1, inside_s1;
    logic [CW-1:0] dx_s1, col_s1;
    logic [RW-1:0] dy_s1;
    logic [FW-1:0] frame_s1;
`ifdef SPRITE_MIRROR_EN
    logic          mirror_s1;
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            valid_s1  <= 1'b0;
            inside_s1 <= 1'b0;
            dx_s1     <= '0;
            dy_s1     <= '0;
            frame_s1  <= '0;
`ifdef SPRITE_MIRROR_EN
            mirror_s1 <= 1'b0;
`endif
        end else begin
            valid_s1  <= 1'b1;
            inside_s1 <= inside_c;
            dx_s1     <= dx_c;
            dy_s1     <= dy_c;
            frame_s1  <= frame_idx;
`ifdef SPRITE_MIRROR_EN
            mirror_s1 <= mirror_x;
`endif
        end
    end

`ifdef SPRITE_MIRROR_EN
    assign col_s1 = mirror_s1 ? (CW'(OBJ_W - 1) - dx_s1) : dx_s1;
`else
    assign col_s1 = dx_s1;
`endif

    // ------------------------------------------------------------------
    // Stage 2: ROM read register drives mVGA_RGB directly; the hit flag
    // travels alongside it so the request lines up with the colour.
    // ------------------------------------------------------------------
    logic valid_s2, inside_s2;

    sprite_rom #(
        .OBJ_W  (OBJ_W),
        .OBJ_H  (OBJ_H),
        .FRAMES (FRAMES)
    ) u_rom (
        .CLK    (CLK),
        .RESETn (RESETn),
        .frame  (frame_s1),
        .row    (dy_s1),
        .col    (col_s1),
        .data   (mVGA_RGB)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            valid_s2  <= 1'b0;
            inside_s2 <= 1'b0;
        end else begin
            valid_s2  <= valid_s1;
            inside_s2 <= valid_s1 && inside_s1;
        end
    end

    assign drawing_request = valid_s2 && inside_s2 && (mVGA_RGB != TRANSPARENT);

    // ------------------------------------------------------------------
    // Animation FSM and tick counter
    // ------------------------------------------------------------------
    anim_state_t   state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [FW-1:0] frame_n;
    logic          done_n;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            tick      <= '0;
            frame_idx <= '0;
            anim_done <= 1'b0;
        end else begin
            state     <= state_n;
            tick      <= tick_n;
            frame_idx <= frame_n;
            anim_done <= done_n;
        end
    end

    // Entering PLAY needs no frame boundary since the bitmap stays at 0;
    // every transition that changes frame_idx waits for startOfFrame.
    always_comb begin
        state_n = state;
        tick_n  = tick;
        frame_n = frame_idx;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                tick_n  = '0;
                frame_n = '0;
                if (play) begin
                    state_n = PLAY;
                end
            end
            PLAY: begin
                if (startOfFrame) begin
                    if (!play) begin
                        state_n = IDLE;
                        tick_n  = '0;
                        frame_n = '0;
                    end else if (tick == LAST_TICK) begin
                        tick_n = '0;
                        if (frame_idx == LAST_FRAME) begin
                            if (loop) begin
                                frame_n = '0;
                            end else begin
                                state_n = DONE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            frame_n = frame_idx + FW'(1);
                        end
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
            end
            DONE: begin
                if (startOfFrame && !play) begin
                    state_n = IDLE;
                    tick_n  = '0;
                    frame_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                tick_n  = '0;
                frame_n = '0;
            end
        endcase
    end

endmodule
